// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: chunk width and per-stage control word.
package adder_pkg;

  function automatic int chunk_w(input int n, input int stages);
    return n / stages;
  endfunction

  // Control bits that ride alongside each chunk of data through the pipeline.
  typedef struct packed {
    logic valid;
    logic carry;
    logic a_sign;
    logic b_sign;
  } stage_t;

endpackage

// File: rtl/adder_stage.sv
// One pipeline slice: adds the lowest W bits of the remaining operands plus the incoming carry,
// shifts the result chunk into the top of the running sum, and registers everything under en.
module adder_stage
  import adder_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  stage_t       ctl_i,
  input  logic [N-1:0] sum_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output stage_t       ctl_o,
  output logic [N-1:0] sum_o,
  output logic [N-1:0] a_o,
  output logic [N-1:0] b_o
);

  logic [W:0]   chunk;
  logic [N-1:0] chunk_ext;
  stage_t       ctl_d, ctl_q;
  logic [N-1:0] sum_d, sum_q;
  logic [N-1:0] a_d, a_q;
  logic [N-1:0] b_d, b_q;

  // Result chunks enter at the top and move down, so after the last stage S is in place.
  always_comb begin
    chunk       = {1'b0, a_i[W-1:0]} + {1'b0, b_i[W-1:0]} + {{W{1'b0}}, ctl_i.carry};
    chunk_ext   = N'(chunk[W-1:0]);
    ctl_d       = ctl_i;
    ctl_d.carry = chunk[W];
    sum_d       = (sum_i >> W) | (chunk_ext << (N - W));
    a_d         = a_i >> W;
    b_d         = b_i >> W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q <= '0;
      sum_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (en) begin
      ctl_q <= ctl_d;
      sum_q <= sum_d;
      a_q   <= a_d;
      b_q   <= b_d;
    end
  end

  assign ctl_o = ctl_q;
  assign sum_o = sum_q;
  assign a_o   = a_q;
  assign b_o   = b_q;

endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep chunked adder with carry-in/out, signed overflow flag and valid/ready flow control.
// Optional saturation of S on overflow is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         co,
  output logic         ovf
);

  localparam int W = chunk_w(N, STAGES);

  if (N % STAGES != 0) begin : g_bad_params
    $error("pipelined_adder: N must be a multiple of STAGES");
  end

  // Valid/ready: a beat moves on a rising edge when valid && ready. The whole pipe advances
  // as one (adv); while the output is stalled every stage holds, so in_ready follows adv.
  logic         adv;
  stage_t       ctl_in;
  logic [N-1:0] sum_in;
  stage_t       ctl_o [STAGES];
  logic [N-1:0] sum_o [STAGES];
  logic [N-1:0] a_o   [STAGES];
  logic [N-1:0] b_o   [STAGES];

  assign ctl_in = '{valid: in_valid, carry: ci, a_sign: A[N-1], b_sign: B[N-1]};
  assign sum_in = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      adder_stage #(.N(N), .W(W)) u_stage (
        .clk(clk), .rst(rst), .en(adv),
        .ctl_i(ctl_in), .sum_i(sum_in), .a_i(A), .b_i(B),
        .ctl_o(ctl_o[k]), .sum_o(sum_o[k]), .a_o(a_o[k]), .b_o(b_o[k])
      );
    end else begin : g_next
      adder_stage #(.N(N), .W(W)) u_stage (
        .clk(clk), .rst(rst), .en(adv),
        .ctl_i(ctl_o[k-1]), .sum_i(sum_o[k-1]), .a_i(a_o[k-1]), .b_i(b_o[k-1]),
        .ctl_o(ctl_o[k]), .sum_o(sum_o[k]), .a_o(a_o[k]), .b_o(b_o[k])
      );
    end
  end

  stage_t       last;
  logic [N-1:0] sum_raw;
  logic         ovf_raw;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
`endif

  always_comb begin
    last    = ctl_o[STAGES-1];
    sum_raw = sum_o[STAGES-1];
    ovf_raw = (last.a_sign == last.b_sign) && (sum_raw[N-1] != last.a_sign);
    adv     = !last.valid || out_ready;
`ifdef PIPELINED_ADDER_SAT_EN
    S       = ovf_raw ? (last.a_sign ? SAT_MIN : SAT_MAX) : sum_raw;
`else
    S       = sum_raw;
`endif
  end

  assign in_ready  = adv;
  assign out_valid = last.valid;
  assign co        = last.carry;
  assign ovf       = ovf_raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench: a 32-bit/4-stage adder and an 8-bit/1-stage adder against arithmetic models.
module tb_pipelined_adder;
  localparam int N  = 32;
  localparam int ST = 4;
  localparam int M  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
  logic [N-1:0] A, B, S;
  logic         in_valid8, in_ready8, ci8, out_valid8, out_ready8, co8, ovf8;
  logic [M-1:0] A8, B8, S8;

  pipelined_adder #(.N(N), .STAGES(ST)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .ci(ci),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .co(co), .ovf(ovf)
  );

  pipelined_adder #(.N(M), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(A8), .B(B8), .ci(ci8),
    .out_valid(out_valid8), .out_ready(out_ready8), .S(S8), .co(co8), .ovf(ovf8)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int pops32   = 0;
  int pops8    = 0;
  int acc8     = 0;
  logic [N+1:0] exp_q[$];
  logic [M+1:0] exp8_q[$];
  logic [N+1:0] e32;
  logic [M+1:0] e8;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [N-1:0] POS_OVF_S = 32'h7FFF_FFFF;
  localparam logic [N-1:0] NEG_OVF_S = 32'h8000_0000;
`else
  localparam logic [N-1:0] POS_OVF_S = 32'h8000_0000;
  localparam logic [N-1:0] NEG_OVF_S = 32'h7FFF_FFFF;
`endif

  // Reference: unsigned sum gives S/co; signed range check gives ovf and the saturation value.
  function automatic logic [N+1:0] model32(input logic [N-1:0] a, b, input logic c);
    logic [N:0]   us;
    longint       ss;
    logic         v;
    logic [N-1:0] s;
    us = {1'b0, a} + {1'b0, b} + (N+1)'(c);
    ss = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
    s  = us[N-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (ss > 64'sd2147483647) s = 32'h7FFF_FFFF;
    else if (ss < -64'sd2147483648) s = 32'h8000_0000;
`endif
    return {v, us[N], s};
  endfunction

  function automatic logic [M+1:0] model8(input logic [M-1:0] a, b, input logic c);
    logic [M:0]   us;
    int           ss;
    logic         v;
    logic [M-1:0] s;
    us = {1'b0, a} + {1'b0, b} + (M+1)'(c);
    ss = int'($signed(a)) + int'($signed(b)) + int'(c);
    v  = (ss > 127) || (ss < -128);
    s  = us[M-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (ss > 127) s = 8'h7F;
    else if (ss < -128) s = 8'h80;
`endif
    return {v, us[M], s};
  endfunction

  function automatic logic [N-1:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboards: sample handshakes mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        pops32++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb32_unexpected: got S=%h co=%b ovf=%b, required no output", S, co, ovf);
        end else begin
          e32 = exp_q.pop_front();
          if ({ovf, co, S} !== e32) begin
            n_fail++;
            $display("FAIL sb32_data: got ovf=%b co=%b S=%h, required ovf=%b co=%b S=%h",
                     ovf, co, S, e32[N+1], e32[N], e32[N-1:0]);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model32(A, B, ci));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp8_q.delete();
    end else begin
      if (out_valid8 && out_ready8) begin
        n_checks++;
        pops8++;
        if (exp8_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb8_unexpected: got S=%h co=%b ovf=%b, required no output", S8, co8, ovf8);
        end else begin
          e8 = exp8_q.pop_front();
          if ({ovf8, co8, S8} !== e8) begin
            n_fail++;
            $display("FAIL sb8_data: got ovf=%b co=%b S=%h, required ovf=%b co=%b S=%h",
                     ovf8, co8, S8, e8[M+1], e8[M], e8[M-1:0]);
          end
        end
      end
      if (in_valid8 && in_ready8) begin
        exp8_q.push_back(model8(A8, B8, ci8));
        acc8++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [N-1:0] a, b, input logic c);
    int t;
    in_valid = 1'b1; A = a; B = b; ci = c;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain32();
    int t;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain32: %0d results outstanding, required 0", exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; A = 32'h1234_5678; B = 32'h1; ci = 1'b1; out_ready = 1'b0;
    in_valid8 = 1'b1; A8 = 8'h55; B8 = 8'h11; ci8 = 1'b0; out_ready8 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b/%b, required 0/0", out_valid, out_valid8);
    end
    n_checks++;
    if ({S, co, ovf} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got S=%h co=%b ovf=%b, required all 0", S, co, ovf);
    end
    tick();
    in_valid = 1'b0; in_valid8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, in_ready8);
    end
    tick();
    out_ready = 1'b1; out_ready8 = 1'b1;
  endtask

  task automatic test_directed(input string name, input logic [N-1:0] a, b, input logic c,
                               input logic [N-1:0] exp_s, input logic exp_co, exp_ovf);
    int lat;
    out_ready = 1'b1;
    in_valid = 1'b1; A = a; B = b; ci = c;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_accept: in_ready=%b, required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    n_checks++;
    if (lat != ST) begin
      n_fail++; $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, ST);
    end
    n_checks++;
    if (S !== exp_s || co !== exp_co || ovf !== exp_ovf) begin
      n_fail++;
      $display("FAIL %s_result: got S=%h co=%b ovf=%b, required S=%h co=%b ovf=%b",
               name, S, co, ovf, exp_s, exp_co, exp_ovf);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int start;
    logic [N+1:0] cap;
    start = pops32;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(pick32(), pick32(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) tick();
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          n_checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_ready: out_valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
          end
          if (j == 0) begin
            cap = {ovf, co, S};
          end else begin
            n_checks++;
            if ({ovf, co, S} !== cap) begin
              n_fail++;
              $display("FAIL stall_hold: got %h, required held %h", {ovf, co, S}, cap);
            end
          end
          tick();
        end
        out_ready = 1'b1;
      end
    join
    drain32();
    n_checks++;
    if (pops32 - start != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d results, required 8", pops32 - start);
    end
  endtask

  task automatic test_reset_flush();
    int start;
    int bad;
    start = pops32;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat($urandom(), $urandom(), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid: out_valid=%b after reset, required 0", out_valid);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || pops32 != start) begin
      n_fail++;
      $display("FAIL flush_leak: %0d valid cycles, %0d results, required 0/0", bad, pops32 - start);
    end
    tick();
  endtask

  task automatic test_random32();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = pick32();
      B         = pick32();
      ci        = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain32();
  endtask

  task automatic test_small();
    int lat;
    int start;
    int t;
    out_ready8 = 1'b1;
    in_valid8 = 1'b1; A8 = 8'd200; B8 = 8'd100; ci8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL small_accept: in_ready=%b, required 1", in_ready8);
    end
    tick();
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 20);
    n_checks++;
    if (lat != 1) begin
      n_fail++; $display("FAIL small_latency: got %0d cycles, required 1", lat);
    end
    n_checks++;
    if (S8 !== 8'd44 || co8 !== 1'b1 || ovf8 !== 1'b0) begin
      n_fail++;
      $display("FAIL small_result: got S=%0d co=%b ovf=%b, required S=44 co=1 ovf=0", S8, co8, ovf8);
    end
    tick();
    start = acc8;
    t = 0;
    while (acc8 - start < 10000 && t < 40000) begin
      in_valid8  = ($urandom_range(0, 7) != 0);
      A8         = 8'($urandom());
      B8         = 8'($urandom());
      ci8        = 1'($urandom_range(0, 1));
      out_ready8 = ($urandom_range(0, 4) != 0);
      tick();
      t++;
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    t = 0;
    while ((exp8_q.size() != 0 || out_valid8) && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (acc8 - start < 10000 || exp8_q.size() != 0) begin
      n_fail++;
      $display("FAIL small_random: accepted %0d with %0d outstanding, required >=10000 with 0",
               acc8 - start, exp8_q.size());
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; A = '0; B = '0; ci = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; A8 = '0; B8 = '0; ci8 = 1'b0; out_ready8 = 1'b1;
    test_reset();
    test_directed("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    test_directed("carry_all", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    test_directed("pos_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, POS_OVF_S,     1'b0, 1'b1);
    test_directed("neg_ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, NEG_OVF_S,     1'b1, 1'b1);
    test_directed("mixed_ci",  32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_flush();
    test_random32();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
